// File: rtl/gray_rx_decoder.sv
// Gray-code receiver: samples gray_in on clk_en, decodes to binary, classifies each step
// and tracks lock/fault. Optional input synchronizer under macro GRAY_RX_SYNC_EN.
module gray_rx_decoder #(
   parameter int N         = 8,
   parameter int ERR_LIMIT = 3,
   parameter int RELOCK    = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_en,
   input  logic [N-1:0]     gray_in,
   output logic [N-1:0]     bin_out,
   output logic             valid,
   output logic             dir_up,
   output logic             dir_dn,
   output logic             step_err,
   output logic             wrap,
   output logic             locked,
   output logic             fault,
   output logic [CNT_W-1:0] err_count
);

   localparam int EW = $clog2(ERR_LIMIT + 1);
   localparam int GW = $clog2(RELOCK + 1);
   localparam logic [EW-1:0]    ERR_LIM    = EW'(ERR_LIMIT);
   localparam logic [GW-1:0]    RELOCK_LIM = GW'(RELOCK);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [N-1:0]     STEP_ONE   = N'(1);
   localparam logic [N-1:0]     ALL_ONES   = '1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_FAULT} state_t;

   logic [N-1:0] sample_g;

`ifdef GRAY_RX_SYNC_EN
   logic [N-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = gray_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign sample_g = sync2_q;
`else
   assign sample_g = gray_in;
`endif

   state_t           state_q, state_d;
   logic [N-1:0]     b_prev_q, b_prev_d;
   logic [N-1:0]     bin_q, bin_d;
   logic             valid_q, valid_d;
   logic             dir_up_q, dir_up_d;
   logic             dir_dn_q, dir_dn_d;
   logic             step_err_q, step_err_d;
   logic             wrap_q, wrap_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [EW-1:0]    err_run_q, err_run_d;
   logic [GW-1:0]    good_run_q, good_run_d;

   logic [N-1:0] b_new;
   logic [N-1:0] diff;
   logic         is_up, is_dn, is_hold, is_ill;

   // MSB-first XOR chain: each binary bit folds in the next Gray bit.
   always_comb begin
      b_new = '0;
      b_new[N-1] = sample_g[N-1];
      for (int i = N - 2; i >= 0; i--) begin
         b_new[i] = b_new[i+1] ^ sample_g[i];
      end
   end

   always_comb begin
      diff    = b_new - b_prev_q;
      is_up   = (diff == STEP_ONE);
      is_dn   = (diff == ALL_ONES);
      is_hold = (diff == '0);
      is_ill  = !(is_up || is_dn || is_hold);
   end

   always_comb begin
      state_d    = state_q;
      b_prev_d   = b_prev_q;
      bin_d      = bin_q;
      valid_d    = 1'b0;
      dir_up_d   = dir_up_q;
      dir_dn_d   = dir_dn_q;
      step_err_d = 1'b0;
      wrap_d     = 1'b0;
      err_cnt_d  = err_cnt_q;
      err_run_d  = err_run_q;
      good_run_d = good_run_q;

      if (clk_en) begin
         valid_d  = 1'b1;
         bin_d    = b_new;
         b_prev_d = b_new;
         if (state_q == ST_IDLE) begin
            // First sample only seeds b_prev; there is nothing to compare against.
            dir_up_d = 1'b0;
            dir_dn_d = 1'b0;
            state_d  = ST_LOCKED;
         end else begin
            dir_up_d   = is_up;
            dir_dn_d   = is_dn;
            step_err_d = is_ill;
            wrap_d     = (is_up && b_new == '0) || (is_dn && b_new == ALL_ONES);
            if (is_ill && err_cnt_q != CNT_MAX) begin
               err_cnt_d = err_cnt_q + 1'b1;
            end
            if (state_q == ST_LOCKED) begin
               if (is_ill) begin
                  err_run_d = err_run_q + 1'b1;
                  if (err_run_d == ERR_LIM) begin
                     state_d    = ST_FAULT;
                     good_run_d = '0;
                  end
               end else begin
                  err_run_d = '0;
               end
            end else begin
               if (is_up || is_dn) begin
                  good_run_d = good_run_q + 1'b1;
                  if (good_run_d == RELOCK_LIM) begin
                     state_d   = ST_LOCKED;
                     err_run_d = '0;
                  end
               end else if (is_ill) begin
                  good_run_d = '0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         b_prev_q   <= '0;
         bin_q      <= '0;
         valid_q    <= 1'b0;
         dir_up_q   <= 1'b0;
         dir_dn_q   <= 1'b0;
         step_err_q <= 1'b0;
         wrap_q     <= 1'b0;
         err_cnt_q  <= '0;
         err_run_q  <= '0;
         good_run_q <= '0;
      end else begin
         state_q    <= state_d;
         b_prev_q   <= b_prev_d;
         bin_q      <= bin_d;
         valid_q    <= valid_d;
         dir_up_q   <= dir_up_d;
         dir_dn_q   <= dir_dn_d;
         step_err_q <= step_err_d;
         wrap_q     <= wrap_d;
         err_cnt_q  <= err_cnt_d;
         err_run_q  <= err_run_d;
         good_run_q <= good_run_d;
      end
   end

   assign bin_out   = bin_q;
   assign valid     = valid_q;
   assign dir_up    = dir_up_q;
   assign dir_dn    = dir_dn_q;
   assign step_err  = step_err_q;
   assign wrap      = wrap_q;
   assign locked    = (state_q == ST_LOCKED);
   assign fault     = (state_q == ST_FAULT);
   assign err_count = err_cnt_q;

endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
- Receive side of the Gray counter path: samples an N-bit Gray word on a clock-enable strobe (the same 1 Hz-style pulse used by the counter side) and decodes it to binary.
- Classifies each step as up, down, hold or illegal, and tracks lock state with a small FSM.
- Keeps a saturating error count, so a bench or board can check a Gray source end-to-end.

Parameters:
- N, 8, Gray/binary word width (N >= 2).
- ERR_LIMIT, 3, consecutive illegal steps that force FAULT.
- RELOCK, 4, consecutive legal non-hold steps required to leave FAULT.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  sample strobe; gray_in is captured only on cycles where clk_en=1.
- gray_in  in  N  Gray-coded input word.
- bin_out  out  N  registered binary decode of the last sample.
- valid  out  1  one-cycle pulse, asserted the cycle after a sample is taken.
- dir_up  out  1  last classified step was +1 (mod 2^N).
- dir_dn  out  1  last classified step was -1 (mod 2^N).
- step_err  out  1  one-cycle pulse, together with valid, on an illegal step.
- wrap  out  1  one-cycle pulse, together with valid, on step 2^N-1 -> 0 (up) or 0 -> 2^N-1 (down).
- locked  out  1  FSM is in LOCKED.
- fault  out  1  FSM is in FAULT.
- err_count  out  CNT_W  saturating total of illegal steps.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, previous-sample register and both run counters = 0. rst has priority over clk_en.
- Decode, combinational from sampled word g: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i] for i=N-2..0.
- Latency: clk_en high at edge k -> bin_out, flags and valid updated at edge k+1. valid is high for exactly one cycle per strobe.
- Step classification, with d = (b_new - b_prev) mod 2^N, N-bit wraparound arithmetic:
  - d=1: up.
  - d=2^N-1: down.
  - d=0: hold.
  - any other d: illegal.
- dir_up/dir_dn are updated on up/down steps. On hold or illegal both are cleared to 0.
- step_err and wrap are pulses, never held.
- err_count increments by 1 per illegal step while in LOCKED or FAULT. It saturates at 2^CNT_W-1 with no wrap and is cleared only by rst.
- FSM:
  - IDLE: on the first strobe, load b_prev, emit valid, classify nothing (all step flags 0), go to LOCKED.
  - LOCKED: each strobe is classified.
    - Illegal step increments the error-run counter; a legal step (including hold) clears it.
    - When the error-run counter reaches ERR_LIMIT, go to FAULT and clear the good-run counter.
  - FAULT: up/down steps increment the good-run counter; an illegal step clears it; hold leaves it unchanged.
    - When the good-run counter reaches RELOCK, go to LOCKED and clear the error-run counter.
- b_prev is updated on every strobe, including illegal ones, so classification is always relative to the last sample.
- rst asserted mid-operation returns to IDLE on the next edge. It discards the pending sample; valid is not asserted.
- With clk_en held high every cycle, the block accepts one sample per cycle with no stall.

Optional Feature:
- Macro GRAY_RX_SYNC_EN.
- Defined: gray_in passes through a two-flop synchronizer (both flops reset to 0) before sampling. Sampling still occurs on clk_en, and total strobe-to-valid latency is still 1 cycle, measured from the synchronized value. The word seen by the decoder lags the pins by 2 cycles, so the bench must hold gray_in stable for at least 2 cycles before the strobe.
- Undefined: gray_in is sampled directly and no synchronizer flops exist.

Test Plan:
- Reset then first strobe with gray_in=8'h00 -> valid=1 one cycle later, bin_out=0, locked=1, no step flags.
- Feed the 8-bit Gray up-sequence 0..255 then 0 (one strobe per value) -> dir_up=1 throughout, wrap pulses once at 255->0, err_count=0.
- Down-sequence 3,2,1,0,255 in Gray (8'h02,8'h03,8'h01,8'h00,8'h80) -> dir_dn=1, wrap on 0->255, bin_out=255.
- From bin 5 (8'h07), strobe 8'h0C (bin 8) three times in a row -> step_err on the first only (later samples are holds), err_count=1, no fault. Next, alternate Gray 8'h00/8'h0C for 3 strobes -> 3 consecutive illegal steps, fault=1, err_count=4.
- In FAULT, 4 consecutive +1 steps -> locked=1 after the 4th valid. A hold mixed in does not reset the good-run count.
- Assert rst for one cycle mid-sequence while clk_en=1 -> next edge: all outputs 0, FSM IDLE. The next strobe produces no classification.
